// File: rtl/vrddata_reorder_buf_if.sv
// Bank-return write bus and per-port drain outputs of the virtual-bank read-data reorder buffer.
// Per-port fields are flat vectors, with port r at [r*FIELD +: FIELD] and word k at [k*FIELD +: FIELD].
interface vrddata_reorder_buf_if #(
    parameter int WIDTH      = 256,
    parameter int NUMRDPT    = 4,
    parameter int NUMVBNK    = 4,
    parameter int NUMWPB     = 2,
    parameter int READ_DELAY = 30,
    parameter int BITRDPT    = 2,
    parameter int BITRDLY    = 5
);
    localparam int NW = NUMVBNK * NUMWPB;

    logic [NW-1:0]                     vld;
    logic [NW*WIDTH-1:0]               din;
    logic [NW*BITRDPT-1:0]             prt;
    logic [NW*BITRDLY-1:0]             ptr;
    logic [NUMRDPT*BITRDLY-1:0]        head;
    logic [NUMRDPT*WIDTH-1:0]          dout;
    logic [NUMRDPT-1:0]                dout_vld;
    logic [NUMRDPT*(BITRDLY+1)-1:0]    cnt;
    logic                              coll_err;
    logic                              ovr_err;
    logic                              rng_err;

    modport master (
        output vld, din, prt, ptr,
        input  head, dout, dout_vld, cnt, coll_err, ovr_err, rng_err
    );

    modport slave (
        input  vld, din, prt, ptr,
        output head, dout, dout_vld, cnt, coll_err, ovr_err, rng_err
    );
endinterface

// File: rtl/vrddata_reorder_buf.sv
// Per-read-port reorder buffer: bank words land in (port, slot) and drain in slot order via a shared head.
// Latency: a word written to the current head slot appears on dout one cycle later; no backpressure.
module vrddata_reorder_buf #(
    parameter int WIDTH      = 256,
    parameter int NUMRDPT    = 4,
    parameter int NUMVBNK    = 4,
    parameter int NUMWPB     = 2,
    parameter int READ_DELAY = 30,
    parameter int BITRDPT    = 2,
    parameter int BITRDLY    = 5
) (
    input  logic clk,
    input  logic rst,
    vrddata_reorder_buf_if.slave bus
);
    localparam int NW = NUMVBNK * NUMWPB;
    localparam int CW = BITRDLY + 1;

    logic [BITRDLY-1:0]    head_q, head_d;
    logic [READ_DELAY-1:0] valid_q [NUMRDPT];
    logic [READ_DELAY-1:0] valid_d [NUMRDPT];
    logic [WIDTH-1:0]      data_q  [NUMRDPT][READ_DELAY];
    logic [WIDTH-1:0]      dout_q  [NUMRDPT];
    logic [WIDTH-1:0]      dout_d  [NUMRDPT];
    logic [NUMRDPT-1:0]    dout_vld_q, dout_vld_d;
    logic [CW-1:0]         cnt_q   [NUMRDPT];
    logic [CW-1:0]         cnt_d   [NUMRDPT];
    logic                  coll_q, coll_d, ovr_q, ovr_d, rng_q, rng_d;

    logic [READ_DELAY-1:0] wr_hit  [NUMRDPT];
    logic [NUMRDPT-1:0]    fwd_hit;
    logic [WIDTH-1:0]      fwd_dat [NUMRDPT];
    logic [NW-1:0]         wr_ok;

    always_comb begin : write_decode
        logic [BITRDPT-1:0] pk;
        logic [BITRDLY-1:0] sk;
        coll_d  = 1'b0;
        ovr_d   = 1'b0;
        rng_d   = 1'b0;
        fwd_hit = '0;
        wr_ok   = '0;
        for (int r = 0; r < NUMRDPT; r++) begin
            wr_hit[r]  = '0;
            fwd_dat[r] = '0;
        end
        // Ascending k, so the highest-indexed word claims a shared slot last.
        for (int k = 0; k < NW; k++) begin
            pk = bus.prt[k*BITRDPT +: BITRDPT];
            sk = bus.ptr[k*BITRDLY +: BITRDLY];
            if (bus.vld[k]) begin
                if (int'(pk) >= NUMRDPT || int'(sk) >= READ_DELAY) begin
                    rng_d = 1'b1;
                end else begin
                    wr_ok[k] = 1'b1;
                    if (wr_hit[pk][sk])
                        coll_d = 1'b1;
                    wr_hit[pk][sk] = 1'b1;
                    if (valid_q[pk][sk] && sk != head_q)
                        ovr_d = 1'b1;
                    if (sk == head_q) begin
                        fwd_hit[pk] = 1'b1;
                        fwd_dat[pk] = bus.din[k*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin : drain
        head_d = (head_q == BITRDLY'(READ_DELAY - 1)) ? '0 : head_q + 1'b1;
        for (int r = 0; r < NUMRDPT; r++) begin
            dout_d[r]     = dout_q[r];
            dout_vld_d[r] = 1'b0;
            if (fwd_hit[r]) begin
                dout_d[r]     = fwd_dat[r];
                dout_vld_d[r] = 1'b1;
            end else if (valid_q[r][head_q]) begin
                dout_d[r]     = data_q[r][head_q];
                dout_vld_d[r] = 1'b1;
            end
            // The head slot is consumed this cycle, so a forwarded write never becomes resident.
            valid_d[r]         = valid_q[r] | wr_hit[r];
            valid_d[r][head_q] = 1'b0;
            cnt_d[r]           = CW'($countones(valid_d[r]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            dout_vld_q <= '0;
            coll_q     <= 1'b0;
            ovr_q      <= 1'b0;
            rng_q      <= 1'b0;
            for (int r = 0; r < NUMRDPT; r++) begin
                valid_q[r] <= '0;
                dout_q[r]  <= '0;
                cnt_q[r]   <= '0;
            end
        end else begin
            head_q     <= head_d;
            dout_vld_q <= dout_vld_d;
            coll_q     <= coll_d;
            ovr_q      <= ovr_d;
            rng_q      <= rng_d;
            for (int r = 0; r < NUMRDPT; r++) begin
                valid_q[r] <= valid_d[r];
                dout_q[r]  <= dout_d[r];
                cnt_q[r]   <= cnt_d[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NW; k++) begin
            if (wr_ok[k])
                data_q[bus.prt[k*BITRDPT +: BITRDPT]][bus.ptr[k*BITRDLY +: BITRDLY]]
                    <= bus.din[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        for (int r = 0; r < NUMRDPT; r++) begin
            bus.head[r*BITRDLY +: BITRDLY] = head_q;
            bus.dout[r*WIDTH +: WIDTH]     = dout_q[r];
            bus.cnt[r*CW +: CW]            = cnt_q[r];
        end
        bus.dout_vld = dout_vld_q;
        bus.coll_err = coll_q;
        bus.ovr_err  = ovr_q;
        bus.rng_err  = rng_q;
    end
endmodule

// File: tb/tb_vrddata_reorder_buf.sv
// Randomised and directed stimulus for the read-data reorder buffer, checked against a slot-array model.
module tb_vrddata_reorder_buf;
    localparam int W = 256, NP = 4, NW = 8, RD = 30, BP = 2, BD = 5, CW = 6;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    vrddata_reorder_buf_if bus ();

    vrddata_reorder_buf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: which slots hold a word, what they hold, and the shared drain position.
    int         m_head;
    bit         m_vld [NP][RD];
    logic [W-1:0] m_dat [NP][RD];
    logic [W-1:0] m_dout [NP];
    bit         m_dv [NP];
    bit         m_coll, m_ovr, m_rng;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.vld = '0;
        bus.din = '0;
        bus.prt = '0;
        bus.ptr = '0;
    endtask

    task automatic set_word(input int k, input int p, input int s, input logic [W-1:0] d);
        bus.vld[k]          = 1'b1;
        bus.prt[k*BP +: BP] = BP'(p);
        bus.ptr[k*BD +: BD] = BD'(s);
        bus.din[k*W +: W]   = d;
    endtask

    task automatic model_step();
        int           hits [NP][RD];
        logic [W-1:0] wd   [NP][RD];
        int p, s;
        m_coll = 0; m_ovr = 0; m_rng = 0;
        if (rst) begin
            m_head = 0;
            for (int r = 0; r < NP; r++) begin
                m_dout[r] = '0;
                m_dv[r]   = 0;
                for (int i = 0; i < RD; i++) m_vld[r][i] = 0;
            end
            return;
        end
        for (int r = 0; r < NP; r++)
            for (int i = 0; i < RD; i++) hits[r][i] = 0;
        for (int k = 0; k < NW; k++) begin
            if (bus.vld[k]) begin
                p = int'(bus.prt[k*BP +: BP]);
                s = int'(bus.ptr[k*BD +: BD]);
                if (p >= NP || s >= RD) m_rng = 1;
                else begin
                    if (hits[p][s] > 0) m_coll = 1;
                    if (m_vld[p][s] && s != m_head) m_ovr = 1;
                    hits[p][s]++;
                    wd[p][s] = bus.din[k*W +: W];
                end
            end
        end
        for (int r = 0; r < NP; r++) begin
            if (hits[r][m_head] > 0) begin
                m_dout[r] = wd[r][m_head]; m_dv[r] = 1;
            end else if (m_vld[r][m_head]) begin
                m_dout[r] = m_dat[r][m_head]; m_dv[r] = 1;
            end else m_dv[r] = 0;
            for (int i = 0; i < RD; i++)
                if (hits[r][i] > 0 && i != m_head) begin
                    m_vld[r][i] = 1; m_dat[r][i] = wd[r][i];
                end
            m_vld[r][m_head] = 0;
        end
        m_head = (m_head + 1) % RD;
    endtask

    task automatic check_all();
        int n;
        for (int r = 0; r < NP; r++) begin
            n = 0;
            for (int i = 0; i < RD; i++) n += int'(m_vld[r][i]);
            chk($sformatf("head[%0d]", r), W'(bus.head[r*BD +: BD]), W'(m_head));
            chk($sformatf("dout_vld[%0d]", r), W'(bus.dout_vld[r]), W'(m_dv[r]));
            chk($sformatf("dout[%0d]", r), bus.dout[r*W +: W], m_dout[r]);
            chk($sformatf("cnt[%0d]", r), W'(bus.cnt[r*CW +: CW]), W'(n));
        end
        chk("coll_err", W'(bus.coll_err), W'(m_coll));
        chk("ovr_err", W'(bus.ovr_err), W'(m_ovr));
        chk("rng_err", W'(bus.rng_err), W'(m_rng));
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        clear_inputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_head(input int h);
        for (int i = 0; i < RD && m_head != h; i++) cyc();
    endtask

    initial begin
        clear_inputs();
        m_head = 0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;

        // Idle: head sweeps and wraps, nothing drains.
        chk("head_after_rst", W'(bus.head[BD-1:0]), W'(0));
        idle(30);
        chk("head_wrap", W'(bus.head[BD-1:0]), W'(0));
        idle(10);

        // Write ahead of the head, drain two cycles later.
        wait_head(5);
        set_word(0, 0, 7, W'(256'hA5));
        cyc();
        chk("s2_cnt_held", W'(bus.cnt[CW-1:0]), W'(1));
        idle(2);
        chk("s2_dv", W'(bus.dout_vld[0]), W'(1));
        chk("s2_dout", bus.dout[W-1:0], W'(256'hA5));
        chk("s2_cnt_back", W'(bus.cnt[CW-1:0]), W'(0));
        idle(1);
        chk("s2_dv_pulse", W'(bus.dout_vld[0]), W'(0));

        // Collision: the higher-indexed word survives.
        wait_head(0);
        set_word(0, 2, 9, W'(256'hB0));
        set_word(7, 2, 9, W'(256'hB3));
        cyc();
        chk("s3_coll", W'(bus.coll_err), W'(1));
        wait_head(9);
        cyc();
        chk("s3_dout", bus.dout[2*W +: W], W'(256'hB3));

        // Write straight into the head slot: forwarded, not counted, not an overrun.
        set_word(3, 3, m_head, W'(256'hC4));
        cyc();
        chk("s4_dv", W'(bus.dout_vld[3]), W'(1));
        chk("s4_dout", bus.dout[3*W +: W], W'(256'hC4));
        chk("s4_cnt", W'(bus.cnt[3*CW +: CW]), W'(0));
        chk("s4_ovr", W'(bus.ovr_err), W'(0));

        // Overwrite a pending slot.
        wait_head(0);
        set_word(2, 1, 12, W'(256'hD1));
        cyc();
        idle(2);
        set_word(5, 1, 12, W'(256'hD2));
        cyc();
        chk("s5_ovr", W'(bus.ovr_err), W'(1));
        wait_head(12);
        cyc();
        chk("s5_dout", bus.dout[W +: W], W'(256'hD2));

        // Out-of-range slot, then fill every port and reset mid-flight.
        set_word(1, 0, 30, W'(256'hEE));
        cyc();
        chk("s6_rng", W'(bus.rng_err), W'(1));
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < NW; k++)
                set_word(k, k % NP, (m_head + 3 + k + c * 3) % RD, {8{$urandom}});
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("s6_rst_cnt", W'(bus.cnt), W'(0));
        chk("s6_rst_dv", W'(bus.dout_vld), W'(0));
        idle(RD + 2);

        // Random traffic, including out-of-range slots and occasional resets.
        for (int c = 0; c < 500; c++) begin
            for (int k = 0; k < NW; k++)
                if ($urandom_range(0, 2) == 0)
                    set_word(k, $urandom_range(0, NP - 1), $urandom_range(0, 31), {8{$urandom}});
            rst = ($urandom_range(0, 99) == 0);
            cyc();
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
